// File: rtl/cam_capture_ctrl_pkg.sv
// Shared types and constants for the camera capture path.
// Holds the FSM state encoding, default frame geometry and the RGB565 -> RGB332 packer.
package cam_pkg;

    localparam int H_PIXELS_DEF = 160;
    localparam int V_LINES_DEF  = 120;
    localparam int ADDR_W_DEF   = 15;
    localparam int FRAME_PIXELS = H_PIXELS_DEF * V_LINES_DEF;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_SYNC    = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } cam_state_e;

    // Keep the top 3 bits of red, top 3 of green (hi[2:0]) and top 2 of blue (lo[4:3]).
    function automatic logic [7:0] rgb565_to_rgb332(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:5], hi[2:0], lo[4:3]};
    endfunction

endpackage

// File: rtl/cam_capture_ctrl_if.sv
// Camera-in / frame-buffer-out signal bundle for cam_capture_ctrl.
// With CAM_FRAME_CNT_EN defined the bundle also carries the 8-bit frame counter.
interface cam_capture_ctrl_if #(parameter int ADDR_W = 15);

    logic              start;
    logic              pclk_rise;
    logic              vsync;
    logic              href;
    logic [7:0]        cam_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              busy;
    logic              frame_done;
`ifdef CAM_FRAME_CNT_EN
    logic [7:0]        frame_cnt;

    modport master (output start, pclk_rise, vsync, href, cam_data,
                    input  mem_we, mem_addr, mem_data, busy, frame_done, frame_cnt);
    modport slave  (input  start, pclk_rise, vsync, href, cam_data,
                    output mem_we, mem_addr, mem_data, busy, frame_done, frame_cnt);
`else
    modport master (output start, pclk_rise, vsync, href, cam_data,
                    input  mem_we, mem_addr, mem_data, busy, frame_done);
    modport slave  (input  start, pclk_rise, vsync, href, cam_data,
                    output mem_we, mem_addr, mem_data, busy, frame_done);
`endif

endinterface

// File: rtl/cam_capture_ctrl_pixel_packer.sv
// Pairs qualified camera bytes into one registered RGB332 pixel plus a one-cycle valid strobe.
// A low href realigns the byte phase, so an odd trailing byte of a line is dropped.
module cam_pixel_packer
    import cam_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic       i_clear,
    input  logic       i_href,
    input  logic [7:0] i_data,
    output logic       o_pix_valid,
    output logic [7:0] o_pix_data
);

    logic       r_phase;
    logic [7:0] r_hi;
    logic       r_pix_valid;
    logic [7:0] r_pix_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase     <= 1'b0;
            r_hi        <= 8'h00;
            r_pix_valid <= 1'b0;
            r_pix_data  <= 8'h00;
        end else begin
            r_pix_valid <= 1'b0;
            if (i_clear) begin
                r_phase <= 1'b0;
            end else if (i_en) begin
                if (!i_href) begin
                    r_phase <= 1'b0;
                end else if (!r_phase) begin
                    r_hi    <= i_data;
                    r_phase <= 1'b1;
                end else begin
                    r_pix_data  <= rgb565_to_rgb332(r_hi, i_data);
                    r_pix_valid <= 1'b1;
                    r_phase     <= 1'b0;
                end
            end
        end
    end

    assign o_pix_valid = r_pix_valid;
    assign o_pix_data  = r_pix_data;

endmodule

// File: rtl/cam_capture_ctrl.sv
// Single-frame camera capture sequencer: arm on start, lock to a full VSYNC pulse, write RGB332 pixels linearly.
// Optional macro CAM_FRAME_CNT_EN adds an 8-bit wrapping completed-frame counter.
//
// state   | meaning
// IDLE    | waiting for start
// ARM     | waiting for a qualified vsync=1 (refuse to join a frame mid-way)
// SYNC    | waiting for vsync to fall; entry to CAPTURE resets addr and byte phase
// CAPTURE | packing byte pairs and writing pixels
// DONE    | one-cycle frame_done pulse, then back to IDLE
module cam_capture_ctrl
    import cam_pkg::*;
#(
    parameter int H_PIXELS = H_PIXELS_DEF,
    parameter int V_LINES  = V_LINES_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    cam_capture_ctrl_if.slave cam
);

    localparam int                FRAME_PX  = H_PIXELS * V_LINES;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PX - 1);

    cam_state_e        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_busy;
    logic              r_frame_done;

    logic       w_qual_vs;
    logic       w_pack_en;
    logic       w_pack_clr;
    logic       w_pix_valid;
    logic [7:0] w_pix_data;
    logic       w_last_wr;

    assign w_qual_vs  = cam.pclk_rise & cam.vsync;
    // A qualified vsync=1 ends the frame, so it must never also feed the packer.
    assign w_pack_en  = (r_state == ST_CAPTURE) & cam.pclk_rise & ~cam.vsync;
    assign w_pack_clr = (r_state == ST_SYNC) & cam.pclk_rise & ~cam.vsync;
    assign w_last_wr  = w_pix_valid & (r_addr == LAST_ADDR);

    cam_pixel_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .i_en        (w_pack_en),
        .i_clear     (w_pack_clr),
        .i_href      (cam.href),
        .i_data      (cam.cam_data),
        .o_pix_valid (w_pix_valid),
        .o_pix_data  (w_pix_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_addr       <= '0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cam.start) begin
                        r_state <= ST_ARM;
                        r_busy  <= 1'b1;
                    end
                end
                ST_ARM: begin
                    if (w_qual_vs) r_state <= ST_SYNC;
                end
                ST_SYNC: begin
                    if (w_pack_clr) begin
                        r_state <= ST_CAPTURE;
                        r_addr  <= '0;
                    end
                end
                ST_CAPTURE: begin
                    if (w_pix_valid && !w_last_wr) r_addr <= r_addr + 1'b1;
                    if (w_last_wr || w_qual_vs) begin
                        r_state      <= ST_DONE;
                        r_frame_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CAM_FRAME_CNT_EN
    logic [7:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_frame_cnt <= 8'h00;
        end else if (r_state == ST_DONE) begin
            r_frame_cnt <= r_frame_cnt + 8'h01;
        end
    end

    assign cam.frame_cnt = r_frame_cnt;
`endif

    assign cam.mem_we     = w_pix_valid;
    assign cam.mem_addr   = r_addr;
    assign cam.mem_data   = w_pix_data;
    assign cam.busy       = r_busy;
    assign cam.frame_done = r_frame_done;

endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl with a frame-level reference model and per-cycle write checker.
// Build with CAM_FRAME_CNT_EN defined to also exercise the frame counter.
module tb_cam_capture_ctrl;
    import cam_pkg::*;

    localparam int FP = FRAME_PIXELS;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    cam_capture_ctrl_if #(.ADDR_W(15)) vif ();

    cam_capture_ctrl #(.H_PIXELS(160), .V_LINES(120), .ADDR_W(15)) dut (
        .clk (clk),
        .rst (rst),
        .cam (vif)
    );

    int checks   = 0;
    int failures = 0;

    int cyc = 0;
    int exp_addr[$];
    int exp_data[$];
    int log_addr[$];
    int log_data[$];
    int act_done = 0;
    int exp_done = 0;
    int last_we_cyc = -1;
    int last_we_addr = -1;
    int done_cyc = -1;
    logic busy_after_done = 1'b1;
    bit done_pend = 0;
    logic prev_fd = 1'b0;

    // frame-level model: are we waiting for vsync high, vsync low, or capturing
    bit         m_active = 0;
    int         m_phase = 0;
    int         m_addr = 0;
    bit         m_have_hi = 0;
    logic [7:0] m_hi = 8'h00;
    int         m_frames = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Truncate each RGB565 channel to its most significant bits.
    function automatic int to332(input logic [7:0] hi, input logic [7:0] lo);
        int px, r5, g6, b5;
        px = {16'h0, hi, lo};
        r5 = (px >> 11) & 31;
        g6 = (px >> 5) & 63;
        b5 = px & 31;
        return ((r5 >> 2) << 5) | ((g6 >> 3) << 2) | (b5 >> 3);
    endfunction

    task automatic model_finish();
        m_active = 0;
        exp_done++;
        m_frames = (m_frames + 1) % 256;
    endtask

    task automatic model_step(input bit v, input bit h, input logic [7:0] d);
        if (!m_active) return;
        if (m_phase == 1) begin
            if (v) m_phase = 2;
        end else if (m_phase == 2) begin
            if (!v) begin
                m_phase = 3; m_addr = 0; m_have_hi = 0;
            end
        end else begin
            if (v) model_finish();
            else if (!h) m_have_hi = 0;
            else if (!m_have_hi) begin
                m_hi = d; m_have_hi = 1;
            end else begin
                exp_addr.push_back(m_addr);
                exp_data.push_back(to332(m_hi, d));
                m_have_hi = 0;
                m_addr++;
                if (m_addr == FP) model_finish();
            end
        end
    endtask

    task automatic qcyc(input bit v, input bit h, input logic [7:0] d);
        vif.pclk_rise = 1'b1;
        vif.vsync     = v;
        vif.href      = h;
        vif.cam_data  = d;
        model_step(v, h, d);
        @(posedge clk); #1;
        vif.pclk_rise = 1'b0;
    endtask

    task automatic pair(input logic [7:0] a, input logic [7:0] b);
        qcyc(1'b0, 1'b1, a);
        qcyc(1'b0, 1'b1, b);
    endtask

    task automatic idle(input int n);
        vif.pclk_rise = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_start();
        vif.start = 1'b1;
        vif.pclk_rise = 1'b0;
        if (!m_active) begin
            m_active = 1; m_phase = 1;
        end
        @(posedge clk); #1;
        vif.start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 20 && act_done != exp_done; i++) @(negedge clk);
        check(name, act_done, exp_done);
        @(posedge clk); #1;
        idle(2);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            if (vif.mem_we) begin
                log_addr.push_back(int'(vif.mem_addr));
                log_data.push_back(int'(vif.mem_data));
                last_we_cyc  = cyc;
                last_we_addr = int'(vif.mem_addr);
                if (exp_addr.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    check("wr_addr", vif.mem_addr, exp_addr.pop_front());
                    check("wr_data", vif.mem_data, exp_data.pop_front());
                end
                check("we_implies_busy", vif.busy, 1);
            end
            if (done_pend) begin
                busy_after_done = vif.busy;
                done_pend = 0;
            end
            if (vif.frame_done) begin
                act_done++;
                done_cyc = cyc;
                done_pend = 1;
                check("done_one_cycle", prev_fd, 0);
            end
            prev_fd = vif.frame_done;
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        vif.start = 1'b0; vif.pclk_rise = 1'b0; vif.vsync = 1'b0;
        vif.href = 1'b0; vif.cam_data = 8'h00;

        // reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", vif.busy, 0);
        check("rst_we", vif.mem_we, 0);
        check("rst_addr", vif.mem_addr, 0);
        check("rst_data", vif.mem_data, 0);
        check("rst_done", vif.frame_done, 0);
`ifdef CAM_FRAME_CNT_EN
        check("rst_frame_cnt", vif.frame_cnt, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        idle(2);

        // first pixels of a line
        clear_log();
        do_start();
        qcyc(1'b1, 1'b0, 8'h00);
        qcyc(1'b0, 1'b0, 8'h00);
        pair(8'hF8, 8'h00);
        pair(8'h07, 8'hE0);
        qcyc(1'b0, 1'b0, 8'h00);
        idle(3);
        check("basic_nwr", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("basic_a0", log_addr[0], 0);
            check("basic_d0", log_data[0], 8'hE0);
            check("basic_a1", log_addr[1], 1);
            check("basic_d1", log_data[1], 8'h1C);
        end
        qcyc(1'b1, 1'b0, 8'h00);
        wait_done("basic_done");
`ifdef CAM_FRAME_CNT_EN
        check("fc_first", vif.frame_cnt, 1);
`endif

        // odd byte count then realigned next line
        clear_log();
        do_start();
        qcyc(1'b1, 1'b0, 8'h00);
        qcyc(1'b0, 1'b0, 8'h00);
        qcyc(1'b0, 1'b1, 8'h12);
        qcyc(1'b0, 1'b1, 8'h34);
        qcyc(1'b0, 1'b1, 8'h56);
        qcyc(1'b0, 1'b0, 8'h00);
        pair(8'hFF, 8'hFF);
        qcyc(1'b0, 1'b0, 8'h00);
        idle(3);
        check("odd_nwr", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("odd_d0", log_data[0], 8'h0A);
            check("odd_a1", log_addr[1], 1);
            check("odd_d1", log_data[1], 8'hFF);
        end
        qcyc(1'b1, 1'b0, 8'h00);
        wait_done("odd_done");

        // start while the camera is already mid-frame; start while busy is ignored
        clear_log();
        qcyc(1'b0, 1'b0, 8'h00);
        idle(3);
        do_start();
        for (int i = 0; i < 10; i++) qcyc(1'b0, 1'b1, 8'(i * 17));
        idle(2);
        check("mid_nowr", log_addr.size(), 0);
        qcyc(1'b1, 1'b0, 8'h00);
        qcyc(1'b0, 1'b0, 8'h00);
        pair(8'hAB, 8'hCD);
        do_start();
        pair(8'h11, 8'h22);
        qcyc(1'b0, 1'b0, 8'h00);
        idle(3);
        check("mid_nwr", log_addr.size(), 2);
        if (log_addr.size() == 2) begin
            check("mid_a0", log_addr[0], 0);
            check("mid_d0", log_data[0], 8'hAD);
        end
        d0 = act_done;
        check("mid_no_early_done", act_done, exp_done);
        qcyc(1'b1, 1'b0, 8'h00);
        wait_done("mid_done");
        check("mid_one_done", act_done, d0 + 1);
        check("mid_busy_low", vif.busy, 0);

        // short frame: vsync after 50 pixels
        clear_log();
        do_start();
        qcyc(1'b1, 1'b0, 8'h00);
        qcyc(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 50; i++) pair(8'(i), 8'(i ^ 8'hFF));
        qcyc(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 12; i++) qcyc(1'b0, 1'b1, 8'h5A);
        wait_done("short_done");
        check("short_nwr", log_addr.size(), 50);
        check("short_last_addr", last_we_addr, 49);
`ifdef CAM_FRAME_CNT_EN
        check("short_fc", vif.frame_cnt, m_frames);
`endif

        // reset in the middle of CAPTURE at addr 37
        clear_log();
        do_start();
        qcyc(1'b1, 1'b0, 8'h00);
        qcyc(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 37; i++) pair(8'(i + 3), 8'(i * 5));
        idle(3);
        check("pre_rst_addr", vif.mem_addr, 37);
        d0 = act_done;
        rst = 1'b0;
        m_active = 0; m_frames = 0;
        exp_addr.delete(); exp_data.delete();
        @(posedge clk);
        @(negedge clk);
        check("mrst_busy", vif.busy, 0);
        check("mrst_we", vif.mem_we, 0);
        check("mrst_addr", vif.mem_addr, 0);
`ifdef CAM_FRAME_CNT_EN
        check("mrst_fc", vif.frame_cnt, 0);
`endif
        @(posedge clk); #1;
        rst = 1'b1;
        idle(4);
        check("mrst_no_done", act_done, d0);

        // full 160x120 frame
        clear_log();
        do_start();
        qcyc(1'b1, 1'b0, 8'h00);
        qcyc(1'b0, 1'b0, 8'h00);
        for (int ln = 0; ln < 120; ln++) begin
            for (int b = 0; b < 320; b++) qcyc(1'b0, 1'b1, 8'(b * 3 + ln * 5));
            qcyc(1'b0, 1'b0, 8'h00);
        end
        for (int i = 0; i < 10; i++) qcyc(1'b0, 1'b1, 8'hC3);
        wait_done("full_done");
        check("full_nwr", log_addr.size(), FP);
        check("full_last_addr", last_we_addr, 19199);
        check("full_done_latency", done_cyc, last_we_cyc + 1);
        check("full_busy_after", busy_after_done, 0);
`ifdef CAM_FRAME_CNT_EN
        check("full_fc", vif.frame_cnt, 1);

        // 256 short frames wrap the counter back
        for (int f = 0; f < 256; f++) begin
            do_start();
            qcyc(1'b1, 1'b0, 8'h00);
            qcyc(1'b0, 1'b0, 8'h00);
            qcyc(1'b1, 1'b0, 8'h00);
            idle(4);
        end
        check("wrap_fc", vif.frame_cnt, 1);
        check("wrap_done_cnt", act_done, exp_done);
`endif

        check("exp_queue_empty", exp_addr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
Single-frame capture sequencer for the OV7670-style camera path. It qualifies camera VSYNC/HREF/D[7:0] with the one-cycle PCLK rising-edge strobe from the upstream PCLK edge detector. It packs byte pairs (RGB565) into 8-bit RGB332 pixels and writes them to the frame-buffer RAM with a linear address counter. Capture is armed by a start request from the top-level controller, which is told when the frame completes.

Parameters:
H_PIXELS, 160, pixels per line
V_LINES, 120, lines per frame
ADDR_W, 15, frame-buffer address width; must satisfy 2^ADDR_W >= H_PIXELS*V_LINES

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  asynchronous, active-low reset (asserted when 0)
start  in  1  capture request; sampled in IDLE only
pclk_rise  in  1  one-clk-cycle strobe per camera PCLK rising edge
vsync  in  1  camera VSYNC, already synchronised to clk
href  in  1  camera HREF, already synchronised to clk
cam_data  in  8  camera data byte, already synchronised to clk
mem_we  out  1  frame-buffer write strobe, one cycle per pixel
mem_addr  out  ADDR_W  frame-buffer write address
mem_data  out  8  RGB332 pixel
busy  out  1  high in every state except IDLE
frame_done  out  1  one-cycle pulse on frame completion

Behaviour:
- Reset values: all outputs 0; state = IDLE; addr counter = 0; byte_phase = 0; hi-byte register = 0.
- vsync, href and cam_data are evaluated only on cycles with pclk_rise=1. Otherwise they are ignored.
- IDLE: start=1 -> ARM. start while busy is ignored (no queuing).
- ARM: wait for vsync=1 on a qualified cycle -> SYNC. This rejects joining a frame mid-way.
- SYNC: wait for vsync=0 on a qualified cycle -> CAPTURE. On entry, addr = 0 and byte_phase = 0.
- CAPTURE, qualified cycle with href=1:
  - byte_phase=0: latch cam_data into hi; set byte_phase = 1.
  - byte_phase=1: mem_data = {hi[7:5], hi[2:0], cam_data[4:3]}; mem_we = 1 on the next clk cycle (registered, latency 1 clk). mem_addr holds the current addr during that cycle. addr then increments and byte_phase = 0.
- CAPTURE, qualified cycle with href=0: byte_phase forced to 0. A dangling odd byte at line end is discarded.
- Frame end, normal: the write at addr = H_PIXELS*V_LINES-1 -> DONE. Later camera bytes are ignored.
- Frame end, short frame: a qualified vsync=1 in CAPTURE -> DONE. Already-written pixels stand; no error flag is raised.
- DONE: frame_done = 1 for exactly one cycle -> IDLE. busy drops in the IDLE cycle.
- mem_we is never asserted outside CAPTURE. mem_addr is never >= H_PIXELS*V_LINES; no wrap-around.
- Reset mid-frame returns the block immediately to IDLE. Partial RAM contents are not cleared.
- FSM encoding: IDLE=0, ARM=1, SYNC=2, CAPTURE=3, DONE=4 (3 bits). Unused codes -> IDLE.

Optional Feature:
Macro CAM_FRAME_CNT_EN.
- Defined: adds output frame_cnt[7:0], reset 0. It increments in the DONE cycle and wraps 255 -> 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package cam_pkg holds:
  - the FSM state constants;
  - localparam FRAME_PIXELS = H_PIXELS*V_LINES;
  - a function rgb565_to_rgb332(hi, lo).
- One natural sub-module: cam_pixel_packer. It contains the byte_phase flag, the hi register and the RGB332 output register. It emits a pix_valid strobe that the FSM/address logic turns into mem_we.

Test Plan:
- Reset low mid-CAPTURE at addr = 37 -> next clk: busy=0, mem_we=0, mem_addr=0; no frame_done.
- start, then vsync 1->0, then one line of href with bytes 0xF8,0x00 -> mem_we pulse with mem_addr=0, mem_data=0xE0; byte pair 0x07,0xE0 -> addr 1, data 0x1C.
- Full frame of 19200 pixels with H_PIXELS=160, V_LINES=120:
  - last write at mem_addr = 19199;
  - frame_done pulses once, 1 cycle after that write;
  - busy=0 on the following cycle;
  - extra bytes produce no mem_we.
- Odd byte count (3 bytes) then href=0, then next line 0xFF,0xFF -> exactly one write from the first pair; next-line pixel data 0xFF (phase realigned).
- start asserted while vsync already low mid-frame -> no writes until vsync goes 1 then 0; first write lands at addr 0.
- Short frame: vsync=1 after 50 pixels -> frame_done pulse, no further writes. With CAM_FRAME_CNT_EN, frame_cnt goes 0 -> 1; after 256 frames it reads 0.
